seq_gen4bit_tx: RTL and testbench
=================================

SEQ_GEN4BIT_TX -- requirements
Module: seq_gen4bit_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, pattern length in bits.
REQ-002 SHALL have parameter DEFAULT_PATTERN, default 4'b1011, pattern sent when use_default=1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate burst; takes priority over all other inputs except rst_n.
REQ-007 SHALL have port use_default  input  1  1 selects DEFAULT_PATTERN, 0 selects pattern.
REQ-008 SHALL have port pattern  input  WIDTH  user pattern, captured on accepted start.
REQ-009 SHALL have port repeat_cnt  input  4  extra repetitions; frames sent = repeat_cnt+1 (1..16).
REQ-010 SHALL have port gap_len  input  4  idle bit-slots between frames (0..15).
REQ-011 SHALL have port ready  input  1  sink accepts data_out this cycle when valid=1.
REQ-012 SHALL have port data_out  output  1  serial bit, MSB first.
REQ-013 SHALL have port valid  output  1  data_out holds a pattern bit.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after last bit of last frame accepted.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, SHIFT, GAP, DONE; all outputs registered or decoded from state/registers only.
REQ-017 IDLE: start=1 and abort=0 SHALL capture pattern/default, repeat_cnt, gap_len, set bit index WIDTH-1, go to SHIFT next cycle.
REQ-018 SHIFT: valid=1, data_out=shift_reg[bit_idx]; a bit is transferred only when valid=1 and ready=1.
REQ-019 SHIFT with ready=0 SHALL hold data_out, valid and bit_idx unchanged (no bit lost, no bit repeated).
REQ-020 Transfer of bit 0 with frames remaining and gap_len=0 SHALL present the next frame's MSB in the very next cycle (back-to-back, e.g. 10111011).
REQ-021 Transfer of bit 0 with frames remaining and gap_len>0 SHALL enter GAP; GAP lasts exactly gap_len cycles with valid=0, data_out=0, independent of ready, then SHIFT at MSB.
REQ-022 Transfer of bit 0 of last frame SHALL enter DONE; DONE asserts done=1, valid=0 for exactly one cycle, then IDLE.
REQ-023 start while busy=1 SHALL be ignored; captured configuration SHALL not change until IDLE.
REQ-024 abort=1 in SHIFT or GAP SHALL go to IDLE next cycle with valid=0, no done pulse; abort in DONE SHALL still give IDLE next cycle (done pulse already issued stands).
REQ-025 start and abort both high in IDLE SHALL remain in IDLE.
REQ-026 Frame counter SHALL be 5 bits wide to hold 16 without wrap; gap counter 4 bits, decrementing to 0.
REQ-027 Latency: first valid bit SHALL appear the cycle after start is accepted; burst with ready=1 lasts (repeat_cnt+1)*WIDTH + repeat_cnt*gap_len cycles plus 1 DONE cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, data_out=0, valid=0, busy=0, done=0, counters and shift register to 0, regardless of clk.
REQ-029 Reset mid-burst SHALL discard the burst; after rst_n rises the block SHALL await a fresh start.

Structure
REQ-030 State encoding (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and DEFAULT_PATTERN value SHALL live in shared package seq4_pkg, shared with the 4-bit detector.
REQ-031 One sub-module is natural: seq_down_counter (loadable 5-bit down-counter with zero flag), instanced for frame and gap counting.

Verification
REQ-032 use_default=1, repeat_cnt=0, gap_len=0, ready=1 -> data_out 1,0,1,1 on cycles 1-4, done at cycle 5, busy low cycle 6.
REQ-033 repeat_cnt=2, gap_len=0 -> 12 bits 101110111011 contiguous; detector chained on data_out reports 3 detections.
REQ-034 pattern=4'b1100, use_default=0, repeat_cnt=1, gap_len=2 -> valid pattern 1,1,0,0,-,-,1,1,0,0 (two valid=0 slots), one done pulse.
REQ-035 ready=0 for 3 cycles while bit index 2 shown -> data_out stays 0 (pattern 1011), sequence resumes unbroken; second start during burst ignored.
REQ-036 abort at bit 1 of frame 2 -> IDLE next cycle, no done; rst_n low mid-GAP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/seq4_pkg.sv
// Shared definitions for the 4-bit sequence generator and its companion detector:
// FSM state encoding, the default pattern and counter widths.
package seq4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } seq4_state_e;

    localparam logic [3:0]  SEQ4_DEFAULT_PATTERN = 4'b1011;
    localparam int unsigned FRAME_CNT_W          = 5;
    localparam int unsigned GAP_CNT_W            = 4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero and flags it; used for both
// frame and gap bookkeeping in the sequence generator.
module seq_down_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Load wins over decrement; decrementing saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/seq_gen4bit_tx.sv
// Serial burst generator: sends a captured pattern MSB first, repeat_cnt+1 times,
// with optional idle gaps between frames and a ready/valid handshake.
module seq_gen4bit_tx
    import seq4_pkg::*;
#(
    // Pattern length; the frame counter scheme below assumes WIDTH >= 2.
    parameter int unsigned      WIDTH           = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = SEQ4_DEFAULT_PATTERN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             use_default,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       repeat_cnt,
    input  logic [3:0]       gap_len,
    input  logic             ready,
    output logic             data_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    seq4_state_e          state_q;
    logic [WIDTH-1:0]     shift_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [GAP_CNT_W-1:0] gap_len_q;
    logic                 data_out_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]       capPattern;
    logic                   xfer;
    logic                   lastBit;
    logic                   frameZero;
    logic                   gapZero;
    logic                   frameLoad;
    logic                   frameDec;
    logic                   gapLoad;
    logic                   gapDec;
    logic [FRAME_CNT_W-1:0] frameLoadVal;
    logic [GAP_CNT_W-1:0]   gapLoadVal;

    assign capPattern = use_default ? DEFAULT_PATTERN : pattern;
    assign xfer       = (state_q == ST_SHIFT) && valid_q && ready && !abort;
    assign lastBit    = (bit_idx_q == '0);

    // The frame counter is loaded with the total frame count and drops as each
    // frame's MSB is accepted, so at bit 0 a zero count means "last frame".
    assign frameLoad    = (state_q == ST_IDLE) && start && !abort;
    assign frameLoadVal = FRAME_CNT_W'(repeat_cnt) + FRAME_CNT_W'(1);
    assign frameDec     = xfer && (bit_idx_q == MSB_IDX);

    // Gap counter is preloaded with gap_len-1 so GAP lasts exactly gap_len cycles.
    assign gapLoad    = xfer && lastBit && !frameZero && (gap_len_q != '0);
    assign gapLoadVal = gap_len_q - GAP_CNT_W'(1);
    assign gapDec     = (state_q == ST_GAP) && !abort;

    seq_down_counter #(
        .W (FRAME_CNT_W)
    ) u_frame_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (frameLoad),
        .load_val_i (frameLoadVal),
        .dec_i      (frameDec),
        .zero_o     (frameZero)
    );

    seq_down_counter #(
        .W (GAP_CNT_W)
    ) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gapLoad),
        .load_val_i (gapLoadVal),
        .dec_i      (gapDec),
        .zero_o     (gapZero)
    );

    // Outputs are computed for the state being entered so they are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            gap_len_q  <= '0;
            data_out_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort) begin
            state_q    <= ST_IDLE;
            data_out_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q    <= capPattern;
                        bit_idx_q  <= MSB_IDX;
                        gap_len_q  <= gap_len;
                        data_out_q <= capPattern[WIDTH-1];
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ready) begin
                        if (!lastBit) begin
                            bit_idx_q  <= bit_idx_q - IDX_W'(1);
                            data_out_q <= shift_q[bit_idx_q - IDX_W'(1)];
                        end else begin
                            bit_idx_q <= MSB_IDX;
                            if (frameZero) begin
                                data_out_q <= 1'b0;
                                valid_q    <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= ST_DONE;
                            end else if (gap_len_q == '0) begin
                                data_out_q <= shift_q[WIDTH-1];
                            end else begin
                                data_out_q <= 1'b0;
                                valid_q    <= 1'b0;
                                state_q    <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gapZero) begin
                        data_out_q <= shift_q[WIDTH-1];
                        valid_q    <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_gen4bit_tx.sv
// Scoreboard bench for seq_gen4bit_tx: directed bursts push expected bits,
// a negedge monitor pops and compares every accepted bit.
module tb_seq_gen4bit_tx;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       start       = 1'b0;
    logic       abort       = 1'b0;
    logic       use_default = 1'b0;
    logic [3:0] pattern     = 4'b0000;
    logic [3:0] repeat_cnt  = 4'd0;
    logic [3:0] gap_len     = 4'd0;
    logic       ready       = 1'b1;
    logic       data_out;
    logic       valid;
    logic       busy;
    logic       done;

    int         compared    = 0;
    int         mismatched  = 0;
    logic       expQ[$];
    int         doneCount   = 0;
    int         gapSlots    = 0;
    int         gapDataHigh = 0;
    int         detectCount = 0;
    logic [3:0] rxHist      = 4'b0000;

    always #5 clk = ~clk;

    seq_gen4bit_tx #(
        .WIDTH           (4),
        .DEFAULT_PATTERN (4'b1011)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .use_default (use_default),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap_len     (gap_len),
        .ready       (ready),
        .data_out    (data_out),
        .valid       (valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushBits(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) expQ.push_back(b[i]);
    endtask

    // Counts negedges until done, comparing the cycle it appeared on.
    task automatic waitDone(input string name, input int expCycles);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        checkOutput({name, " done cycle"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(expCycles));
    endtask

    // Issues one start pulse with the given configuration, ready held high.
    task automatic applyStimulus(input string name, input logic useDef, input logic [3:0] pat,
                                 input logic [3:0] rc, input logic [3:0] gl, input int expDone);
        int doneBefore;
        doneBefore = doneCount;
        @(posedge clk); #1;
        use_default = useDef;
        pattern     = pat;
        repeat_cnt  = rc;
        gap_len     = gl;
        ready       = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(name, expDone);
        @(negedge clk);
        checkOutput({name, " busy after done"}, 32'(busy), 32'd0);
        checkOutput({name, " done pulses"}, 32'(doneCount - doneBefore), 32'd1);
        checkOutput({name, " queue drained"}, 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        logic expBit;
        if (valid && ready) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL serial bit: got data_out=%0b, expected no transfer", data_out);
            end else begin
                expBit = expQ.pop_front();
                checkOutput("serial bit", 32'(data_out), 32'(expBit));
            end
            rxHist = {rxHist[2:0], data_out};
            if (rxHist == 4'b1011) detectCount++;
        end
        if (!busy) rxHist = 4'b0000;
        if (done) doneCount++;
        if (busy && !valid && !done) begin
            gapSlots++;
            if (data_out) gapDataHigh++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int detBefore;
        int gapBefore;
        int gapHighBefore;
        int doneBefore;

        #1;
        checkOutput("reset data_out", 32'(data_out), 32'd0);
        checkOutput("reset valid",    32'(valid),    32'd0);
        checkOutput("reset busy",     32'(busy),     32'd0);
        checkOutput("reset done",     32'(done),     32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Default pattern, single frame: bits on cycles 1-4, done on 5
        pushBits(16'b1011, 4);
        applyStimulus("single default", 1'b1, 4'b0000, 4'd0, 4'd0, 5);

        // Three back-to-back frames, detector model counts 1011 occurrences
        detBefore = detectCount;
        pushBits(16'b101110111011, 12);
        applyStimulus("back to back", 1'b1, 4'b0000, 4'd2, 4'd0, 13);
        checkOutput("detections", 32'(detectCount - detBefore), 32'd3);

        // User pattern with two-slot gap between two frames
        gapBefore     = gapSlots;
        gapHighBefore = gapDataHigh;
        pushBits(16'b11001100, 8);
        applyStimulus("gap pattern", 1'b0, 4'b1100, 4'd1, 4'd2, 11);
        checkOutput("gap slots",     32'(gapSlots - gapBefore),        32'd2);
        checkOutput("gap data high", 32'(gapDataHigh - gapHighBefore), 32'd0);

        // Stall on bit index 2 for three cycles, with an ignored second start
        doneBefore = doneCount;
        pushBits(16'b1011, 4);
        @(posedge clk); #1;
        use_default = 1'b1;
        repeat_cnt  = 4'd0;
        gap_len     = 4'd0;
        ready       = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ready       = 1'b0;
        start       = 1'b1;
        use_default = 1'b0;
        pattern     = 4'b0000;
        repeat_cnt  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall data_out", 32'(data_out), 32'd0);
            checkOutput("stall valid",    32'(valid),    32'd1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        ready = 1'b1;
        waitDone("stall", 4);
        @(negedge clk);
        checkOutput("stall busy after done", 32'(busy), 32'd0);
        checkOutput("stall done pulses", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("stall queue drained", 32'(expQ.size()), 32'd0);

        // Start and abort together in IDLE must not launch a burst
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("start+abort busy", 32'(busy), 32'd0);

        // Abort while bit 1 of frame 2 is presented
        doneBefore = doneCount;
        pushBits(16'b101110, 6);
        @(posedge clk); #1;
        use_default = 1'b1;
        repeat_cnt  = 4'd2;
        gap_len     = 4'd0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        checkOutput("pre-abort bit1", 32'(data_out), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        checkOutput("abort valid", 32'(valid), 32'd0);
        checkOutput("abort busy",  32'(busy),  32'd0);
        checkOutput("abort done",  32'(done),  32'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort no done pulse", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("abort queue drained", 32'(expQ.size()), 32'd0);

        // Asynchronous reset in the middle of a gap
        pushBits(16'b1100, 4);
        @(posedge clk); #1;
        use_default = 1'b0;
        pattern     = 4'b1100;
        repeat_cnt  = 4'd1;
        gap_len     = 4'd3;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("in gap valid", 32'(valid), 32'd0);
        checkOutput("in gap busy",  32'(busy),  32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async rst data_out", 32'(data_out), 32'd0);
        checkOutput("async rst valid",    32'(valid),    32'd0);
        checkOutput("async rst busy",     32'(busy),     32'd0);
        checkOutput("async rst done",     32'(done),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post rst idle busy",    32'(busy), 32'd0);
        checkOutput("post rst queue drained", 32'(expQ.size()), 32'd0);

        // Fresh burst after reset behaves normally
        pushBits(16'b1011, 4);
        applyStimulus("after reset", 1'b1, 4'b0000, 4'd0, 4'd0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
